// File: rtl/pipe_chain.sv
// Linear instruction pipeline chain with per-stage stall, squash, bubble insertion and halt/drain.
// Stage 0 is youngest; stage STAGES-1 is presented on the output with no backpressure.
module pipe_chain #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned STAGES = 4,
   parameter int unsigned IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              stall,
   input  logic [IDX_W-1:0]  stall_idx,
   input  logic              flush,
   input  logic [IDX_W-1:0]  flush_idx,
   input  logic              halt,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [STAGES-1:0] stage_valid,
   output logic [4:0]        occupancy,
   output logic              drained
);

   localparam int unsigned LAST = STAGES - 1;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [DATA_W-1:0] data_q [STAGES];
   logic [DATA_W-1:0] data_d [STAGES];
   logic [DATA_W-1:0] src_data [STAGES];
   logic [4:0]        occ_q, occ_d;
   logic              halt_q, halt_d;

   logic [STAGES-1:0] src_valid, hold_v, bub_v, clr_v, inv_v;
   logic              accept, stall_eff, exit_v;
   logic [4:0]        killed;
   int unsigned       stall_k, flush_f;

   assign in_ready = ~halt & ~halt_q & ~stall & ~flush;

   // Per-stage move selection: each slot holds, takes a bubble, or shifts from below;
   // squash then clears whatever lands in the slot.
   always_comb begin
      accept    = in_valid & in_ready;
      halt_d    = halt_q | halt;
      stall_k   = (32'(stall_idx) > LAST) ? LAST : 32'(stall_idx);
      flush_f   = (32'(flush_idx) > LAST) ? LAST : 32'(flush_idx);
      stall_eff = stall & ~(flush & (stall_k <= flush_f));
      src_valid = {valid_q[STAGES-2:0], accept};
      src_data[0] = in_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
         src_data[i] = data_q[i-1];
      end
      hold_v  = '0;
      bub_v   = '0;
      clr_v   = '0;
      inv_v   = '0;
      valid_d = '0;
      killed  = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         hold_v[i]  = stall_eff && (i <= stall_k);
         bub_v[i]   = stall_eff && (i == stall_k + 1);
         clr_v[i]   = flush && (stall_eff ? (i <= flush_f) : (i <= flush_f + 1));
         inv_v[i]   = hold_v[i] ? valid_q[i] : (bub_v[i] ? 1'b0 : src_valid[i]);
         valid_d[i] = inv_v[i] & ~clr_v[i];
         killed     = killed + 5'(inv_v[i] & clr_v[i]);
         data_d[i]  = (hold_v[i] | bub_v[i]) ? data_q[i] : src_data[i];
      end
      // Items are conserved by hold/shift/bubble; they only enter by accept and leave by exit or squash.
      exit_v = valid_q[LAST] & ~hold_v[LAST];
      occ_d  = occ_q + 5'(accept) - 5'(exit_v) - killed;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         occ_q   <= '0;
         halt_q  <= 1'b0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         halt_q  <= halt_d;
         for (int unsigned i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign stage_valid = valid_q;
   assign out_valid   = valid_q[LAST];
   assign out_data    = data_q[LAST];
   assign occupancy   = occ_q;
   assign drained     = halt_q & (occ_q == 5'd0);

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: 4-stage vector table plus 6-stage stall/flush and async-reset sequences.
module tb_pipe_chain;

   logic        clk = 1'b0;
   logic        rst, in_valid, stall, flush, halt, in_ready, out_valid, drained;
   logic [15:0] in_data, out_data;
   logic [1:0]  stall_idx, flush_idx;
   logic [3:0]  stage_valid;
   logic [4:0]  occupancy;

   logic        rst2, iv2, st2, fl2, hl2, rdy2, ov2, dr2;
   logic [15:0] d2, od2;
   logic [2:0]  si2, fi2;
   logic [5:0]  sv2;
   logic [4:0]  occ2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_chain #(.DATA_W(16), .STAGES(4), .IDX_W(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .stall(stall), .stall_idx(stall_idx), .flush(flush), .flush_idx(flush_idx), .halt(halt),
      .out_valid(out_valid), .out_data(out_data), .stage_valid(stage_valid),
      .occupancy(occupancy), .drained(drained)
   );

   pipe_chain #(.DATA_W(16), .STAGES(6), .IDX_W(3)) dut6 (
      .clk(clk), .rst(rst2), .in_valid(iv2), .in_data(d2), .in_ready(rdy2),
      .stall(st2), .stall_idx(si2), .flush(fl2), .flush_idx(fi2), .halt(hl2),
      .out_valid(ov2), .out_data(od2), .stage_valid(sv2),
      .occupancy(occ2), .drained(dr2)
   );

   typedef struct {
      logic        iv;
      logic [15:0] d;
      logic        st;
      logic [1:0]  si;
      logic        fl;
      logic [1:0]  fi;
      logic        hl;
      logic        rdy;
      logic [3:0]  sv;
      logic [4:0]  occ;
      logic [15:0] od;
      logic        dr;
   } vec_t;

   vec_t vecs [30];

   function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic st,
                               input logic [1:0] si, input logic fl, input logic [1:0] fi,
                               input logic hl, input logic rdy, input logic [3:0] sv,
                               input logic [4:0] occ, input logic [15:0] od, input logic dr);
      vec_t v;
      v.iv = iv; v.d = d; v.st = st; v.si = si; v.fl = fl; v.fi = fi; v.hl = hl;
      v.rdy = rdy; v.sv = sv; v.occ = occ; v.od = od; v.dr = dr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle2();
      iv2 = 1'b0; d2 = '0; st2 = 1'b0; si2 = '0; fl2 = 1'b0; fi2 = '0; hl2 = 1'b0;
   endtask

   // Load the 6-stage chain with base..base+5; base ends up in the output stage.
   task automatic fill2(input logic [15:0] base);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle2();
         iv2 = 1'b1;
         d2  = base + 16'(i);
         @(posedge clk);
      end
      #1;
      check("fill6 sv", 32'(sv2), 32'h3f);
      check("fill6 occ", 32'(occ2), 32'd6);
   endtask

   task automatic reset2();
      @(negedge clk);
      idle2();
      rst2 = 1'b1;
      #2 rst2 = 1'b0;
   endtask

   initial begin
      vecs[0]  = mk(1, 16'h0001, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 16'h0000, 0);
      vecs[1]  = mk(1, 16'h0002, 0, 0, 0, 0, 0, 1, 4'b0011, 2, 16'h0000, 0);
      vecs[2]  = mk(1, 16'h0003, 0, 0, 0, 0, 0, 1, 4'b0111, 3, 16'h0000, 0);
      vecs[3]  = mk(1, 16'h0004, 0, 0, 0, 0, 0, 1, 4'b1111, 4, 16'h0001, 0);
      vecs[4]  = mk(1, 16'h0005, 0, 0, 0, 0, 0, 1, 4'b1111, 4, 16'h0002, 0);
      vecs[5]  = mk(1, 16'h0006, 1, 1, 0, 0, 0, 0, 4'b1011, 3, 16'h0003, 0);
      vecs[6]  = mk(1, 16'h0007, 0, 0, 0, 0, 0, 1, 4'b0111, 3, 16'h0000, 0);
      vecs[7]  = mk(1, 16'h0008, 0, 0, 0, 0, 0, 1, 4'b1111, 4, 16'h0004, 0);
      vecs[8]  = mk(1, 16'h0009, 0, 0, 1, 1, 0, 0, 4'b1000, 1, 16'h0005, 0);
      vecs[9]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'h0000, 0);
      vecs[10] = mk(1, 16'h000a, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 16'h0000, 0);
      vecs[11] = mk(1, 16'h000b, 0, 0, 0, 0, 0, 1, 4'b0011, 2, 16'h0000, 0);
      vecs[12] = mk(1, 16'h000c, 1, 3, 0, 0, 0, 0, 4'b0011, 2, 16'h0000, 0);
      vecs[13] = mk(1, 16'h000c, 1, 3, 1, 3, 0, 0, 4'b0000, 0, 16'h0000, 0);
      vecs[14] = mk(1, 16'h000d, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 16'h0000, 0);
      vecs[15] = mk(1, 16'h000e, 0, 0, 0, 0, 0, 1, 4'b0011, 2, 16'h0000, 0);
      vecs[16] = mk(1, 16'h000f, 0, 0, 0, 0, 0, 1, 4'b0111, 3, 16'h0000, 0);
      vecs[17] = mk(1, 16'h0010, 1, 0, 0, 0, 0, 0, 4'b1101, 3, 16'h000d, 0);
      vecs[18] = mk(1, 16'h0010, 1, 2, 1, 0, 0, 0, 4'b0100, 1, 16'h0000, 0);
      vecs[19] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 4'b1000, 1, 16'h000e, 0);
      vecs[20] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'h0000, 0);
      vecs[21] = mk(1, 16'h0011, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 16'h0000, 0);
      vecs[22] = mk(1, 16'h0012, 0, 0, 0, 0, 0, 1, 4'b0011, 2, 16'h0000, 0);
      vecs[23] = mk(1, 16'h0013, 0, 0, 0, 0, 0, 1, 4'b0111, 3, 16'h0000, 0);
      vecs[24] = mk(1, 16'h0014, 0, 0, 0, 0, 0, 1, 4'b1111, 4, 16'h0011, 0);
      vecs[25] = mk(1, 16'h0015, 0, 0, 0, 0, 1, 0, 4'b1110, 3, 16'h0012, 0);
      vecs[26] = mk(1, 16'h0016, 0, 0, 0, 0, 0, 0, 4'b1100, 2, 16'h0013, 0);
      vecs[27] = mk(1, 16'h0017, 0, 0, 0, 0, 0, 0, 4'b1000, 1, 16'h0014, 0);
      vecs[28] = mk(1, 16'h0018, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 16'h0000, 1);
      vecs[29] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 16'h0000, 1);

      rst = 1'b1; rst2 = 1'b1;
      in_valid = 1'b0; in_data = '0; stall = 1'b0; stall_idx = '0;
      flush = 1'b0; flush_idx = '0; halt = 1'b0;
      idle2();
      #2;
      check("rst sv", 32'(stage_valid), 32'h0);
      check("rst occ", 32'(occupancy), 32'h0);
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst out_data", 32'(out_data), 32'h0);
      check("rst drained", 32'(drained), 32'h0);
      @(negedge clk);
      rst = 1'b0; rst2 = 1'b0;

      // 4-stage table: inputs at negedge, in_ready just after, state just after the edge
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         in_valid = vecs[i].iv; in_data = vecs[i].d;
         stall = vecs[i].st; stall_idx = vecs[i].si;
         flush = vecs[i].fl; flush_idx = vecs[i].fi; halt = vecs[i].hl;
         #1 check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
         @(posedge clk);
         #1;
         check($sformatf("v%0d stage_valid", i), 32'(stage_valid), 32'(vecs[i].sv));
         check($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
         check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].sv[3]));
         if (vecs[i].sv[3])
            check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
         check($sformatf("v%0d drained", i), 32'(drained), 32'(vecs[i].dr));
      end

      // Async reset mid-cycle on a full chain
      @(negedge clk);
      in_valid = 1'b0; halt = 1'b0; stall = 1'b0; flush = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 16'h0100 + 16'(i);
         @(posedge clk);
      end
      #3;
      check("pre-arst out_valid", 32'(out_valid), 32'h1);
      rst = 1'b1;
      #1;
      check("arst out_valid", 32'(out_valid), 32'h0);
      check("arst occ", 32'(occupancy), 32'h0);
      check("arst sv", 32'(stage_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; in_data = 16'h0200;
      #1 check("post-rst in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      check("first accept sv", 32'(stage_valid), 32'h1);
      check("first accept occ", 32'(occupancy), 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         @(posedge clk);
      end
      #1;
      check("latency out_valid", 32'(out_valid), 32'h1);
      check("latency out_data", 32'(out_data), 32'h0200);

      // 6-stage: stall_idx=3 with flush_idx=1
      reset2();
      fill2(16'h0001);
      check("fill6 out_data", 32'(od2), 32'h0001);
      @(negedge clk);
      idle2();
      iv2 = 1'b1; d2 = 16'h0077; st2 = 1'b1; si2 = 3'd3; fl2 = 1'b1; fi2 = 3'd1;
      #1 check("s3f1 in_ready", 32'(rdy2), 32'h0);
      @(posedge clk);
      #1;
      check("s3f1 sv", 32'(sv2), 32'h2c);
      check("s3f1 occ", 32'(occ2), 32'd3);
      check("s3f1 out_data", 32'(od2), 32'h0002);

      // 6-stage: stall_idx=1 with flush_idx=3 behaves as flush alone
      reset2();
      fill2(16'h0011);
      @(negedge clk);
      idle2();
      iv2 = 1'b1; d2 = 16'h0077; st2 = 1'b1; si2 = 3'd1; fl2 = 1'b1; fi2 = 3'd3;
      @(posedge clk);
      #1;
      check("s1f3 sv", 32'(sv2), 32'h20);
      check("s1f3 occ", 32'(occ2), 32'd1);
      check("s1f3 out_data", 32'(od2), 32'h0012);

      // 6-stage: out-of-range indices clamp to the last stage
      reset2();
      fill2(16'h0021);
      @(negedge clk);
      idle2();
      iv2 = 1'b1; d2 = 16'h0077; st2 = 1'b1; si2 = 3'd7;
      @(posedge clk);
      #1;
      check("clamp stall sv", 32'(sv2), 32'h3f);
      check("clamp stall occ", 32'(occ2), 32'd6);
      check("clamp stall out_data", 32'(od2), 32'h0021);
      @(negedge clk);
      idle2();
      fl2 = 1'b1; fi2 = 3'd7;
      @(posedge clk);
      #1;
      check("clamp flush sv", 32'(sv2), 32'h00);
      check("clamp flush occ", 32'(occ2), 32'd0);
      check("clamp flush out_valid", 32'(ov2), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
